// File: rtl/l1d_ram_sched_pkg.sv
// Shared types and helpers for the L1D RAM port scheduler.
package l1d_ram_sched_pkg;

  typedef enum logic {SCHED_INIT, SCHED_RUN} sched_state_e;

  // Address width for a RAM of the given depth; never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester at or above the
// pointer (with wrap-around), then moves the pointer just past the winner.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] vld,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;
  logic [PW-1:0] gnt_idx;
  logic          found;

  // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (en && !found && vld[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/l1d_ram_port_sched.sv
// Read/write port scheduler for a 1R1W L1D register RAM: round-robin grants,
// 1-cycle write-first read responses, and a zero-fill sweep after reset/flush.
module l1d_ram_port_sched
  import l1d_ram_sched_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 8,
  parameter  int NUM_RD = 2,
  parameter  int NUM_WR = 2,
  localparam int AW     = addr_w(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_req_i,
  output logic                    init_done_o,
  input  logic [NUM_RD-1:0]       rd_req_vld_i,
  input  logic [NUM_RD*AW-1:0]    rd_req_addr_i,
  output logic [NUM_RD-1:0]       rd_req_rdy_o,
  output logic [NUM_RD-1:0]       rd_resp_vld_o,
  output logic [WIDTH-1:0]        rd_resp_data_o,
  input  logic [NUM_WR-1:0]       wr_req_vld_i,
  input  logic [NUM_WR*AW-1:0]    wr_req_addr_i,
  input  logic [NUM_WR*WIDTH-1:0] wr_req_data_i,
  output logic [NUM_WR-1:0]       wr_req_rdy_o,
  output logic                    ram_re_o,
  output logic [AW-1:0]           ram_ra_o,
  input  logic [WIDTH-1:0]        ram_rd_i,
  output logic                    ram_we_o,
  output logic [AW-1:0]           ram_wa_o,
  output logic [WIDTH-1:0]        ram_wd_o
);

  sched_state_e      state, state_nxt;
  logic [AW-1:0]     cnt, cnt_nxt;
  logic              run;
  logic [NUM_RD-1:0] rd_gnt;
  logic [NUM_WR-1:0] wr_gnt;
  logic              fwd;

  assign run         = (state == SCHED_RUN);
  assign init_done_o = run;

  // NOTE: the RAM array itself has no reset; the INIT sweep writes zeros to every entry instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SCHED_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      SCHED_INIT: begin
        if (cnt == AW'(DEPTH - 1)) begin
          state_nxt = SCHED_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      SCHED_RUN: begin
        if (flush_req_i) begin
          state_nxt = SCHED_INIT;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = SCHED_INIT;
    endcase
  end

  rr_arbiter #(.N(NUM_RD)) u_rd_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run),
    .vld   (rd_req_vld_i),
    .gnt   (rd_gnt)
  );

  rr_arbiter #(.N(NUM_WR)) u_wr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run),
    .vld   (wr_req_vld_i),
    .gnt   (wr_gnt)
  );

  assign rd_req_rdy_o = rd_gnt;
  assign wr_req_rdy_o = wr_gnt;

  // Grants are zero outside RUN, so the sweep override below never collides with traffic.
  always_comb begin
    ram_re_o = |rd_gnt;
    ram_ra_o = '0;
    ram_we_o = |wr_gnt;
    ram_wa_o = '0;
    ram_wd_o = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_gnt[i]) ram_ra_o = rd_req_addr_i[i*AW +: AW];
    end
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_gnt[i]) begin
        ram_wa_o = wr_req_addr_i[i*AW +: AW];
        ram_wd_o = wr_req_data_i[i*WIDTH +: WIDTH];
      end
    end
    if (!run) begin
      ram_we_o = 1'b1;
      ram_wa_o = cnt;
      ram_wd_o = '0;
      ram_re_o = 1'b0;
    end
  end

  // Same-cycle write to the read address wins over the stale RAM contents.
  assign fwd = ram_we_o && ram_re_o && (ram_wa_o == ram_ra_o);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_resp_vld_o  <= '0;
      rd_resp_data_o <= '0;
    end else begin
      rd_resp_vld_o <= rd_gnt;
      if (|rd_gnt) rd_resp_data_o <= fwd ? ram_wd_o : ram_rd_i;
    end
  end

endmodule

// File: tb/tb_l1d_ram_port_sched.sv
// Self-checking bench for l1d_ram_port_sched: behavioural 1R1W RAM, response
// scoreboard checked one cycle after each expected read grant.
module tb_l1d_ram_port_sched;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 8;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;
  localparam int AW     = 3;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic                    flush_req;
  logic                    init_done;
  logic [NUM_RD-1:0]       rd_req_vld;
  logic [NUM_RD*AW-1:0]    rd_req_addr;
  logic [NUM_RD-1:0]       rd_req_rdy;
  logic [NUM_RD-1:0]       rd_resp_vld;
  logic [WIDTH-1:0]        rd_resp_data;
  logic [NUM_WR-1:0]       wr_req_vld;
  logic [NUM_WR*AW-1:0]    wr_req_addr;
  logic [NUM_WR*WIDTH-1:0] wr_req_data;
  logic [NUM_WR-1:0]       wr_req_rdy;
  logic                    ram_re;
  logic [AW-1:0]           ram_ra;
  logic [WIDTH-1:0]        ram_rd;
  logic                    ram_we;
  logic [AW-1:0]           ram_wa;
  logic [WIDTH-1:0]        ram_wd;

  always #5 clk = ~clk;

  l1d_ram_port_sched #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_req_i    (flush_req),
    .init_done_o    (init_done),
    .rd_req_vld_i   (rd_req_vld),
    .rd_req_addr_i  (rd_req_addr),
    .rd_req_rdy_o   (rd_req_rdy),
    .rd_resp_vld_o  (rd_resp_vld),
    .rd_resp_data_o (rd_resp_data),
    .wr_req_vld_i   (wr_req_vld),
    .wr_req_addr_i  (wr_req_addr),
    .wr_req_data_i  (wr_req_data),
    .wr_req_rdy_o   (wr_req_rdy),
    .ram_re_o       (ram_re),
    .ram_ra_o       (ram_ra),
    .ram_rd_i       (ram_rd),
    .ram_we_o       (ram_we),
    .ram_wa_o       (ram_wa),
    .ram_wd_o       (ram_wd)
  );

  // Behavioural RAM: combinational read, write at the clock edge.
  logic [WIDTH-1:0] tb_mem [DEPTH];
  always @(posedge clk) if (ram_we) tb_mem[ram_wa] <= ram_wd;
  assign ram_rd = tb_mem[ram_ra];

  typedef struct packed {
    logic [NUM_RD-1:0] vld;
    logic [WIDTH-1:0]  data;
  } resp_t;

  resp_t            sb_q[$];
  resp_t            exp_r;
  logic [WIDTH-1:0] last_exp = '0;
  logic [WIDTH-1:0] exp_mem [DEPTH];
  int               rd_ptr_m, wr_ptr_m;
  int               n_tests = 0;
  int               n_fail  = 0;

  function automatic int rr_pick(input logic [1:0] v, input int ptr);
    int j;
    for (int i = 0; i < 2; i++) begin
      j = (ptr + i) % 2;
      if (v[j[0]]) return j;
    end
    return -1;
  endfunction

  task automatic set_rd(input logic [1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_req_vld  = v;
    rd_req_addr = {a1, a0};
  endtask

  task automatic set_wr(input logic [1:0] v, input logic [AW-1:0] a0, input logic [WIDTH-1:0] d0,
                        input logic [AW-1:0] a1, input logic [WIDTH-1:0] d1);
    wr_req_vld  = v;
    wr_req_addr = {a1, a0};
    wr_req_data = {d1, d0};
  endtask

  task automatic zero_model();
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
  endtask

  // Response monitor: one cycle after an expected grant the matching response must appear;
  // otherwise valid stays low and the data holds.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      n_tests++;
      if (sb_q.size() > 0) begin
        exp_r    = sb_q.pop_front();
        last_exp = exp_r.data;
      end else begin
        exp_r = '{vld: '0, data: last_exp};
      end
      if ({rd_resp_vld, rd_resp_data} !== exp_r) begin
        n_fail++;
        $display("FAIL rd_resp @%0t: got vld=%b data=%h, want vld=%b data=%h",
                 $time, rd_resp_vld, rd_resp_data, exp_r.vld, exp_r.data);
      end
    end
  end

  // Checks the zero sweep for cycles 0..DEPTH-1, starting at a negedge in sweep cycle 0.
  task automatic check_sweep(input string name, input logic pulse_flush);
    for (int i = 0; i < DEPTH; i++) begin
      flush_req = pulse_flush && (i == 3);
      #1;
      n_tests++;
      if ({init_done, ram_we, ram_wa, ram_wd, ram_re, rd_req_rdy, wr_req_rdy} !==
          {1'b0, 1'b1, 3'(i), 8'h00, 1'b0, 2'b00, 2'b00}) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got done=%b we=%b wa=%0d wd=%h re=%b rrdy=%b wrdy=%b, want 0 1 %0d 00 0 00 00",
                 name, i, init_done, ram_we, ram_wa, ram_wd, ram_re, rd_req_rdy, wr_req_rdy, i);
      end
      @(negedge clk);
    end
    flush_req = 1'b0;
    set_rd(2'b00, 0, 0);
    set_wr(2'b00, 0, 0, 0, 0);
    #1;
    n_tests++;
    if (init_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done: got init_done=%b, want 1 in cycle %0d", name, init_done, DEPTH);
    end
    zero_model();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    flush_req = 1'b0;
    set_rd(2'b00, 0, 0);
    set_wr(2'b00, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if ({init_done, rd_resp_vld, rd_resp_data, rd_req_rdy, wr_req_rdy} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got done=%b rvld=%b rdata=%h rrdy=%b wrdy=%b, want all 0",
               init_done, rd_resp_vld, rd_resp_data, rd_req_rdy, wr_req_rdy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_rd(2'b11, 3, 5);
    set_wr(2'b11, 1, 8'h11, 2, 8'h22);
    check_sweep("reset_sweep", 1'b0);
    rd_ptr_m = 0;
    wr_ptr_m = 0;
  endtask

  task automatic test_read_rr();
    int g;
    logic [1:0]    er;
    logic [AW-1:0] ea;
    set_rd(2'b11, 3, 5);
    for (int i = 0; i < 6; i++) begin
      #1;
      g  = i % 2;
      er = 2'(1 << g);
      ea = (g == 1) ? 3'd5 : 3'd3;
      n_tests++;
      if ({rd_req_rdy, ram_re, ram_ra} !== {er, 1'b1, ea}) begin
        n_fail++;
        $display("FAIL read_rr %0d: got rdy=%b re=%b ra=%0d, want rdy=%b re=1 ra=%0d",
                 i, rd_req_rdy, ram_re, ram_ra, er, ea);
      end
      sb_q.push_back('{vld: er, data: exp_mem[ea]});
      @(negedge clk);
    end
    rd_ptr_m = 0;
    set_rd(2'b00, 3, 5);
    #1;
    n_tests++;
    if ({ram_re, ram_ra, ram_we, ram_wa, ram_wd, rd_req_rdy, wr_req_rdy} !== '0) begin
      n_fail++;
      $display("FAIL idle_ram: got re=%b ra=%0d we=%b wa=%0d wd=%h rrdy=%b wrdy=%b, want all 0",
               ram_re, ram_ra, ram_we, ram_wa, ram_wd, rd_req_rdy, wr_req_rdy);
    end
    @(negedge clk);
  endtask

  task automatic test_forwarding();
    set_rd(2'b01, 2, 0);
    set_wr(2'b01, 2, 8'hA5, 0, 0);
    #1;
    n_tests++;
    if ({rd_req_rdy, wr_req_rdy, ram_re, ram_ra, ram_we, ram_wa, ram_wd} !==
        {2'b01, 2'b01, 1'b1, 3'd2, 1'b1, 3'd2, 8'hA5}) begin
      n_fail++;
      $display("FAIL fwd_drive: got rrdy=%b wrdy=%b re=%b ra=%0d we=%b wa=%0d wd=%h, want 01 01 1 2 1 2 a5",
               rd_req_rdy, wr_req_rdy, ram_re, ram_ra, ram_we, ram_wa, ram_wd);
    end
    sb_q.push_back('{vld: 2'b01, data: 8'hA5});
    exp_mem[2] = 8'hA5;
    rd_ptr_m   = 1;
    wr_ptr_m   = 1;
    @(negedge clk);
    set_rd(2'b00, 0, 0);
    set_wr(2'b00, 0, 0, 0, 0);
    @(negedge clk);
    // Pointer sits at 1 but only requester 0 asks: the search must wrap.
    set_rd(2'b01, 2, 0);
    #1;
    n_tests++;
    if (rd_req_rdy !== 2'b01) begin
      n_fail++;
      $display("FAIL fwd_wrap_grant: got rdy=%b, want 01", rd_req_rdy);
    end
    sb_q.push_back('{vld: 2'b01, data: exp_mem[2]});
    rd_ptr_m = 1;
    @(negedge clk);
    set_rd(2'b00, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_concurrency();
    int wg, g;
    logic [AW-1:0]    ea;
    logic [WIDTH-1:0] ed;
    set_wr(2'b11, 4, 8'h11, 6, 8'h22);
    set_rd(2'b10, 0, 2);
    for (int i = 0; i < 4; i++) begin
      #1;
      wg = rr_pick(2'b11, wr_ptr_m);
      ea = (wg == 1) ? 3'd6 : 3'd4;
      ed = (wg == 1) ? 8'h22 : 8'h11;
      n_tests++;
      if ({wr_req_rdy, ram_we, ram_wa, ram_wd, rd_req_rdy, ram_re, ram_ra} !==
          {2'(1 << wg), 1'b1, ea, ed, 2'b10, 1'b1, 3'd2}) begin
        n_fail++;
        $display("FAIL concurrency %0d: got wrdy=%b we=%b wa=%0d wd=%h rrdy=%b re=%b ra=%0d, want wrdy=%b 1 %0d %h 10 1 2",
                 i, wr_req_rdy, ram_we, ram_wa, ram_wd, rd_req_rdy, ram_re, ram_ra, 2'(1 << wg), ea, ed);
      end
      sb_q.push_back('{vld: 2'b10, data: exp_mem[2]});
      exp_mem[ea] = ed;
      wr_ptr_m    = (wg + 1) % 2;
      rd_ptr_m    = 0;
      @(negedge clk);
    end
    set_wr(2'b00, 0, 0, 0, 0);
    set_rd(2'b11, 4, 6);
    for (int i = 0; i < 2; i++) begin
      #1;
      g  = rr_pick(2'b11, rd_ptr_m);
      ea = (g == 1) ? 3'd6 : 3'd4;
      n_tests++;
      if ({rd_req_rdy, ram_ra} !== {2'(1 << g), ea}) begin
        n_fail++;
        $display("FAIL readback %0d: got rdy=%b ra=%0d, want rdy=%b ra=%0d", i, rd_req_rdy, ram_ra, 2'(1 << g), ea);
      end
      sb_q.push_back('{vld: 2'(1 << g), data: exp_mem[ea]});
      rd_ptr_m = (g + 1) % 2;
      @(negedge clk);
    end
    set_rd(2'b00, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_flush();
    int g;
    logic [AW-1:0] ea;
    set_wr(2'b10, 0, 0, 7, 8'h5A);
    #1;
    n_tests++;
    if (wr_req_rdy !== 2'b10) begin
      n_fail++;
      $display("FAIL flush_prewrite: got wrdy=%b, want 10", wr_req_rdy);
    end
    exp_mem[7] = 8'h5A;
    wr_ptr_m   = 0;
    @(negedge clk);
    // Flush cycle: the grant sampled alongside the flush must still complete.
    flush_req = 1'b1;
    set_wr(2'b01, 2, 8'h3C, 0, 0);
    set_rd(2'b01, 2, 0);
    #1;
    n_tests++;
    if ({init_done, rd_req_rdy, wr_req_rdy, ram_we, ram_wa, ram_wd} !==
        {1'b1, 2'b01, 2'b01, 1'b1, 3'd2, 8'h3C}) begin
      n_fail++;
      $display("FAIL flush_cycle: got done=%b rrdy=%b wrdy=%b we=%b wa=%0d wd=%h, want 1 01 01 1 2 3c",
               init_done, rd_req_rdy, wr_req_rdy, ram_we, ram_wa, ram_wd);
    end
    sb_q.push_back('{vld: 2'b01, data: 8'h3C});
    rd_ptr_m = 1;
    wr_ptr_m = 1;
    @(negedge clk);
    set_rd(2'b11, 1, 2);
    set_wr(2'b11, 1, 8'hFF, 2, 8'hEE);
    check_sweep("flush_sweep", 1'b1);
    set_rd(2'b11, 2, 7);
    for (int i = 0; i < 2; i++) begin
      #1;
      g  = rr_pick(2'b11, rd_ptr_m);
      ea = (g == 1) ? 3'd7 : 3'd2;
      n_tests++;
      if ({rd_req_rdy, ram_ra} !== {2'(1 << g), ea}) begin
        n_fail++;
        $display("FAIL post_flush_read %0d: got rdy=%b ra=%0d, want rdy=%b ra=%0d", i, rd_req_rdy, ram_ra, 2'(1 << g), ea);
      end
      sb_q.push_back('{vld: 2'(1 << g), data: exp_mem[ea]});
      rd_ptr_m = (g + 1) % 2;
      @(negedge clk);
    end
    set_rd(2'b00, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int g;
    set_wr(2'b01, 1, 8'h77, 0, 0);
    #1;
    exp_mem[1] = 8'h77;
    wr_ptr_m   = (rr_pick(2'b01, wr_ptr_m) + 1) % 2;
    @(negedge clk);
    set_wr(2'b00, 0, 0, 0, 0);
    set_rd(2'b01, 1, 0);
    #1;
    g = rr_pick(2'b01, rd_ptr_m);
    sb_q.push_back('{vld: 2'(1 << g), data: exp_mem[1]});
    rd_ptr_m = (g + 1) % 2;
    @(negedge clk);
    set_rd(2'b00, 0, 0);
    @(negedge clk);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    n_tests++;
    if (ram_wa !== 3'd4) begin
      n_fail++;
      $display("FAIL async_pre: got wa=%0d, want 4", ram_wa);
    end
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    last_exp = '0;
    set_rd(2'b11, 1, 1);
    #1;
    n_tests++;
    if ({init_done, rd_resp_vld, rd_resp_data, rd_req_rdy, wr_req_rdy, ram_we, ram_wa, ram_re} !==
        {1'b0, 2'b00, 8'h00, 2'b00, 2'b00, 1'b1, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_clear: got done=%b rvld=%b rdata=%h rrdy=%b wrdy=%b we=%b wa=%0d re=%b, want 0 00 00 00 00 1 0 0",
               init_done, rd_resp_vld, rd_resp_data, rd_req_rdy, wr_req_rdy, ram_we, ram_wa, ram_re);
    end
    rd_ptr_m = 0;
    wr_ptr_m = 0;
    set_rd(2'b00, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_sweep("async_sweep", 1'b0);
    // Read pointer was 1 before the reset; it must restart at 0.
    set_rd(2'b11, 1, 1);
    #1;
    n_tests++;
    if (rd_req_rdy !== 2'b01) begin
      n_fail++;
      $display("FAIL async_ptr: got rdy=%b, want 01", rd_req_rdy);
    end
    sb_q.push_back('{vld: 2'b01, data: exp_mem[1]});
    rd_ptr_m = 1;
    @(negedge clk);
    set_rd(2'b00, 0, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read_rr();
    test_forwarding();
    test_concurrency();
    test_flush();
    test_async_reset();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_resp: got %0d responses outstanding, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, want finish", $time);
    $fatal(1);
  end

endmodule

// File: doc/l1d_ram_port_sched.md
Name: l1d_ram_port_sched

Overview:
- Scheduler in front of a 1-read/1-write register RAM inside the L1D.
- Shares the single read port among NUM_RD requesters and the single write port among NUM_WR requesters, each with independent round-robin arbitration.
- Returns registered read responses with write-first forwarding.
- Runs a zero-fill sweep of the RAM after reset and on a flush request, so the RAM needs no bulk reset of its own.

Parameters:
- WIDTH, 8, data width of one RAM entry.
- DEPTH, 8, number of RAM entries; AW = $clog2(DEPTH).
- NUM_RD, 2, number of read requesters.
- NUM_WR, 2, number of write requesters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush_req_i  in  1  pulse: re-zero the whole RAM.
- init_done_o  out  1  high while in RUN.
- rd_req_vld_i  in  NUM_RD  read request valid, one bit per requester.
- rd_req_addr_i  in  NUM_RD*AW  read addresses, requester i at bits [i*AW +: AW].
- rd_req_rdy_o  out  NUM_RD  read grant, one-hot or zero.
- rd_resp_vld_o  out  NUM_RD  read response valid, one-hot or zero.
- rd_resp_data_o  out  WIDTH  read response data, shared by all requesters.
- wr_req_vld_i  in  NUM_WR  write request valid.
- wr_req_addr_i  in  NUM_WR*AW  write addresses.
- wr_req_data_i  in  NUM_WR*WIDTH  write data.
- wr_req_rdy_o  out  NUM_WR  write grant, one-hot or zero.
- ram_re_o / ram_ra_o  out  1 / AW  RAM read enable and read address.
- ram_rd_i  in  WIDTH  RAM read data; combinational, same cycle as ram_ra_o.
- ram_we_o / ram_wa_o / ram_wd_o  out  1 / AW / WIDTH  RAM write enable, address and data.

Behaviour:
- Clocking: single clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - State = INIT, init counter = 0.
  - Both round-robin pointers = 0.
  - rd_resp_vld_o = 0, rd_resp_data_o = 0, init_done_o = 0.
- INIT state:
  - Every cycle: ram_we_o = 1, ram_wa_o = counter, ram_wd_o = 0, ram_re_o = 0.
  - All rdy outputs = 0.
  - Counter increments each cycle. In the cycle where counter == DEPTH-1, next state is RUN.
  - The sweep takes exactly DEPTH cycles. flush_req_i is ignored during INIT.
- RUN state:
  - init_done_o = 1.
  - If flush_req_i is sampled high: next state is INIT, counter = 0. Grants in that same cycle are still honoured.
- Arbitration (identical for read and write sides):
  - Grant the first requester with vld = 1, searching from pointer upward with wrap-around.
  - rdy_o[g] = 1 only for the granted requester g, and only in RUN.
  - Handshake is vld & rdy in the same cycle. No rdy is raised without vld.
  - On a grant the pointer becomes (g+1) mod N; it is unchanged when nothing is granted.
  - A requester may hold vld; a dropped request is simply not granted.
- RAM drive, combinational in RUN:
  - ram_re_o = read grant, ram_ra_o = granted read address.
  - ram_we_o = write grant, ram_wa_o / ram_wd_o = granted write address / data.
  - When the respective side is idle, address and data outputs are 0.
- Read response latency is exactly 1 cycle:
  - Grant to requester r in cycle T gives rd_resp_vld_o = one-hot(r) in T+1.
  - rd_resp_data_o = ram_wd_o from cycle T if ram_we_o and ram_wa_o == ram_ra_o in T (write-first); otherwise ram_rd_i from T.
  - rd_resp_data_o holds its value when no response is issued. There is no response backpressure.
- Throughput: one read and one write per cycle, simultaneously, to any addresses.
- Async reset mid-sweep or mid-traffic: outputs clear immediately and any pending response is dropped. After release, a full sweep restarts from address 0.

Decomposition:
- Package l1d_ram_sched_pkg contains:
  - typedef enum logic {SCHED_INIT, SCHED_RUN} sched_state_e;
  - any localparam helpers for AW.
- Sub-module rr_arbiter #(N): inputs vld[N], outputs one-hot gnt[N]; owns its pointer with async active-low reset.
  - Instantiated twice: once for the read side, once for the write side.
- Top-level holds the FSM, the init counter, the RAM muxing and the response register.

Test Plan:
- Reset, DEPTH=8:
  - Release rst_n; for cycles 0..7 expect ram_we_o=1, ram_wa_o=0..7, ram_wd_o=0, all rdy=0.
  - init_done_o rises in cycle 8.
- Read round-robin:
  - Both read requesters hold vld continuously after init, addr0=3, addr1=5.
  - Expect grants 0,1,0,1…; rd_resp_vld_o follows one cycle later with the matching one-hot requester.
- Write-first forwarding:
  - Same cycle: write addr 2 data 0xA5, read addr 2 (old value 0x00).
  - Response next cycle = 0xA5; a later read of addr 2 also returns 0xA5.
- Concurrency and write round-robin:
  - Both writers hold vld; writes alternate 0,1 while a single reader gets a grant every cycle.
  - ram_we_o and ram_re_o are both high each cycle.
- Flush:
  - Pulse flush_req_i during traffic. The same-cycle grant completes and its response appears.
  - init_done_o drops, an 8-cycle zero sweep runs, then reads return 0x00.
- Async reset mid-sweep:
  - Assert rst_n low at counter=4; outputs clear without waiting for a clock edge.
  - After release, the sweep restarts at address 0 and lasts 8 cycles.
